// File: rtl/control_unit_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The control unit is the master: it consumes opcode/flags and drives every enable and select.
interface control_unit_if #(
   parameter int OP_W     = 4,
   parameter int ALU_OP_W = 3
);
   logic [OP_W-1:0]     opcode;
   logic                flag_z;
   logic                flag_n;
   logic                pc_en;
   logic                pc_sel;
   logic                ir_en;
   logic                reg_ab_en;
   logic                alu_b_sel;
   logic [ALU_OP_W-1:0] alu_op;
   logic                acc_en;
   logic                flags_en;
   logic                mar_en;
   logic                mdr_en;
   logic                mem_we;
   logic                wb_sel;
   logic                rf_we;
   logic                retired;
   logic                halted;
   logic                illegal;

   modport master (
      input  opcode, flag_z, flag_n,
      output pc_en, pc_sel, ir_en, reg_ab_en, alu_b_sel, alu_op,
             acc_en, flags_en, mar_en, mdr_en, mem_we, wb_sel, rf_we,
             retired, halted, illegal
   );

   modport slave (
      output opcode, flag_z, flag_n,
      input  pc_en, pc_sel, ir_en, reg_ab_en, alu_b_sel, alu_op,
             acc_en, flags_en, mar_en, mdr_en, mem_we, wb_sel, rf_we,
             retired, halted, illegal
   );
endinterface

// File: rtl/control_unit.sv
// Multicycle control FSM for the accumulator CPU: FETCH/DECODE/EXEC/MEM/WB with a sticky HALT.
// All datapath controls are combinational from the registered state and the IR opcode.
module control_unit #(
   parameter int OP_W     = 4,
   parameter int ALU_OP_W = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   control_unit_if.master cu
);

   localparam logic [OP_W-1:0] OPC_NOP  = OP_W'(4'h0);
   localparam logic [OP_W-1:0] OPC_ADD  = OP_W'(4'h1);
   localparam logic [OP_W-1:0] OPC_SUB  = OP_W'(4'h2);
   localparam logic [OP_W-1:0] OPC_AND  = OP_W'(4'h3);
   localparam logic [OP_W-1:0] OPC_OR   = OP_W'(4'h4);
   localparam logic [OP_W-1:0] OPC_XOR  = OP_W'(4'h5);
   localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(4'h6);
   localparam logic [OP_W-1:0] OPC_LD   = OP_W'(4'h7);
   localparam logic [OP_W-1:0] OPC_ST   = OP_W'(4'h8);
   localparam logic [OP_W-1:0] OPC_BEQ  = OP_W'(4'h9);
   localparam logic [OP_W-1:0] OPC_BNE  = OP_W'(4'hA);
   localparam logic [OP_W-1:0] OPC_BLT  = OP_W'(4'hB);
   localparam logic [OP_W-1:0] OPC_JMP  = OP_W'(4'hC);
   localparam logic [OP_W-1:0] OPC_HLT  = OP_W'(4'hF);

   localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'd0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3'd1);
   localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3'd2);
   localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3'd3);
   localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(3'd4);

   typedef enum logic [2:0] {
      S_INIT,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   stop_hlt;
   logic   stop_hlt_nxt;

   // Opcode classification
   logic                is_nop;
   logic                is_hlt;
   logic                is_alu;
   logic                is_addi;
   logic                is_ld;
   logic                is_st;
   logic                is_branch;
   logic                is_legal;
   logic                br_taken;
   logic [ALU_OP_W-1:0] rtype_op;

   // Control outputs
   logic                pc_en;
   logic                pc_sel;
   logic                ir_en;
   logic                reg_ab_en;
   logic                alu_b_sel;
   logic [ALU_OP_W-1:0] alu_op;
   logic                acc_en;
   logic                flags_en;
   logic                mar_en;
   logic                mdr_en;
   logic                mem_we;
   logic                wb_sel;
   logic                rf_we;
   logic                retired;
   logic                halted;
   logic                illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_INIT;
         stop_hlt <= 1'b0;
      end else begin
         state    <= state_nxt;
         stop_hlt <= stop_hlt_nxt;
      end
   end

   always_comb begin
      is_nop    = (cu.opcode == OPC_NOP);
      is_hlt    = (cu.opcode == OPC_HLT);
      is_alu    = (cu.opcode == OPC_ADD) || (cu.opcode == OPC_SUB) ||
                  (cu.opcode == OPC_AND) || (cu.opcode == OPC_OR)  ||
                  (cu.opcode == OPC_XOR);
      is_addi   = (cu.opcode == OPC_ADDI);
      is_ld     = (cu.opcode == OPC_LD);
      is_st     = (cu.opcode == OPC_ST);
      is_branch = (cu.opcode == OPC_BEQ) || (cu.opcode == OPC_BNE) ||
                  (cu.opcode == OPC_BLT) || (cu.opcode == OPC_JMP);
      is_legal  = is_alu || is_addi || is_ld || is_st || is_branch;
   end

   always_comb begin
      rtype_op = ALU_ADD;
      case (cu.opcode)
         OPC_SUB: rtype_op = ALU_SUB;
         OPC_AND: rtype_op = ALU_AND;
         OPC_OR:  rtype_op = ALU_OR;
         OPC_XOR: rtype_op = ALU_XOR;
         default: rtype_op = ALU_ADD;
      endcase
   end

   // Flags are read live in EXEC; they only change through ALU/ADDI writes.
   always_comb begin
      br_taken = 1'b0;
      case (cu.opcode)
         OPC_BEQ: br_taken = cu.flag_z;
         OPC_BNE: br_taken = !cu.flag_z;
         OPC_BLT: br_taken = cu.flag_n;
         OPC_JMP: br_taken = 1'b1;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      stop_hlt_nxt = stop_hlt;
      pc_en        = 1'b0;
      pc_sel       = 1'b0;
      ir_en        = 1'b0;
      reg_ab_en    = 1'b0;
      alu_b_sel    = 1'b0;
      alu_op       = ALU_ADD;
      acc_en       = 1'b0;
      flags_en     = 1'b0;
      mar_en       = 1'b0;
      mdr_en       = 1'b0;
      mem_we       = 1'b0;
      wb_sel       = 1'b0;
      rf_we        = 1'b0;
      retired      = 1'b0;
      halted       = 1'b0;
      illegal      = 1'b0;

      case (state)
         S_INIT: begin
            state_nxt = S_FETCH;
         end

         S_FETCH: begin
            ir_en     = 1'b1;
            pc_en     = 1'b1;
            state_nxt = S_DECODE;
         end

         S_DECODE: begin
            reg_ab_en = 1'b1;
            if (is_nop) begin
               retired   = 1'b1;
               state_nxt = S_FETCH;
            end else if (is_hlt) begin
               retired      = 1'b1;
               stop_hlt_nxt = 1'b1;
               state_nxt    = S_HALT;
            end else if (is_legal) begin
               state_nxt = S_EXEC;
            end else begin
               stop_hlt_nxt = 1'b0;
               state_nxt    = S_HALT;
            end
         end

         S_EXEC: begin
            if (is_alu) begin
               alu_op    = rtype_op;
               acc_en    = 1'b1;
               flags_en  = 1'b1;
               state_nxt = S_WB;
            end else if (is_addi) begin
               alu_b_sel = 1'b1;
               acc_en    = 1'b1;
               flags_en  = 1'b1;
               state_nxt = S_WB;
            end else if (is_ld || is_st) begin
               alu_b_sel = 1'b1;
               mar_en    = 1'b1;
               state_nxt = S_MEM;
            end else if (is_branch) begin
               pc_sel    = 1'b1;
               pc_en     = br_taken;
               retired   = 1'b1;
               state_nxt = S_FETCH;
            end else begin
               state_nxt = S_FETCH;
            end
         end

         S_MEM: begin
            if (is_ld) begin
               mdr_en    = 1'b1;
               state_nxt = S_WB;
            end else begin
               mem_we    = 1'b1;
               retired   = 1'b1;
               state_nxt = S_FETCH;
            end
         end

         S_WB: begin
            rf_we     = 1'b1;
            wb_sel    = is_ld;
            retired   = 1'b1;
            state_nxt = S_FETCH;
         end

         S_HALT: begin
            halted = stop_hlt;
            illegal = !stop_hlt;
         end

         default: begin
            state_nxt = S_INIT;
         end
      endcase
   end

   assign cu.pc_en     = pc_en;
   assign cu.pc_sel    = pc_sel;
   assign cu.ir_en     = ir_en;
   assign cu.reg_ab_en = reg_ab_en;
   assign cu.alu_b_sel = alu_b_sel;
   assign cu.alu_op    = alu_op;
   assign cu.acc_en    = acc_en;
   assign cu.flags_en  = flags_en;
   assign cu.mar_en    = mar_en;
   assign cu.mdr_en    = mdr_en;
   assign cu.mem_we    = mem_we;
   assign cu.wb_sel    = wb_sel;
   assign cu.rf_we     = rf_we;
   assign cu.retired   = retired;
   assign cu.halted    = halted;
   assign cu.illegal   = illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle comparison against an instruction-timeline model,
// plus hand-computed control vectors at key cycles.
module tb_control_unit;

   localparam int OP_W     = 4;
   localparam int ALU_OP_W = 3;

   // Vector bit order: pc_en pc_sel ir_en reg_ab_en alu_b_sel alu_op[2:0] acc_en flags_en
   //                   mar_en mdr_en mem_we wb_sel rf_we retired halted illegal
   typedef struct packed {
      logic       pc_en;
      logic       pc_sel;
      logic       ir_en;
      logic       reg_ab_en;
      logic       alu_b_sel;
      logic [2:0] alu_op;
      logic       acc_en;
      logic       flags_en;
      logic       mar_en;
      logic       mdr_en;
      logic       mem_we;
      logic       wb_sel;
      logic       rf_we;
      logic       retired;
      logic       halted;
      logic       illegal;
   } ctrl_t;

   localparam logic [17:0] L_ZERO     = 18'h00000;
   localparam logic [17:0] L_FETCH    = 18'h28000;
   localparam logic [17:0] L_DECODE   = 18'h04000;
   localparam logic [17:0] L_DEC_RET  = 18'h04004;
   localparam logic [17:0] L_EXEC_ADD = 18'h00300;
   localparam logic [17:0] L_WB       = 18'h0000C;
   localparam logic [17:0] L_WB_LD    = 18'h0001C;
   localparam logic [17:0] L_MAR      = 18'h02080;
   localparam logic [17:0] L_MDR      = 18'h00040;
   localparam logic [17:0] L_ST_MEM   = 18'h00024;
   localparam logic [17:0] L_BR_TAKEN = 18'h30004;
   localparam logic [17:0] L_BR_NOT   = 18'h10004;
   localparam logic [17:0] L_HALTED   = 18'h00002;
   localparam logic [17:0] L_ILLEGAL  = 18'h00001;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   control_unit_if #(.OP_W(OP_W), .ALU_OP_W(ALU_OP_W)) bus ();

   control_unit #(.OP_W(OP_W), .ALU_OP_W(ALU_OP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cu    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%05h required 0x%05h", name, $time, act, exp);
      end
   endtask

   function automatic ctrl_t dut_vec();
      ctrl_t v;
      v.pc_en     = bus.pc_en;
      v.pc_sel    = bus.pc_sel;
      v.ir_en     = bus.ir_en;
      v.reg_ab_en = bus.reg_ab_en;
      v.alu_b_sel = bus.alu_b_sel;
      v.alu_op    = bus.alu_op;
      v.acc_en    = bus.acc_en;
      v.flags_en  = bus.flags_en;
      v.mar_en    = bus.mar_en;
      v.mdr_en    = bus.mdr_en;
      v.mem_we    = bus.mem_we;
      v.wb_sel    = bus.wb_sel;
      v.rf_we     = bus.rf_we;
      v.retired   = bus.retired;
      v.halted    = bus.halted;
      v.illegal   = bus.illegal;
      return v;
   endfunction

   // Cycles from FETCH through the retiring cycle
   function automatic int instr_len(input logic [3:0] o);
      case (o)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8: return 4;
         4'h7:                                     return 5;
         4'h9, 4'hA, 4'hB, 4'hC:                   return 3;
         default:                                  return 2;
      endcase
   endfunction

   function automatic logic taken(input logic [3:0] o, input logic z, input logic n);
      case (o)
         4'h9:    return z;
         4'hA:    return !z;
         4'hB:    return n;
         default: return 1'b1;
      endcase
   endfunction

   // Expected controls for cycle k of an instruction (k = 0 is its FETCH)
   function automatic ctrl_t model_vec(input logic [3:0] o, input logic z, input logic n, input int k);
      ctrl_t e;
      e = '0;
      if (k == 0) begin
         e.ir_en = 1'b1;
         e.pc_en = 1'b1;
      end else if (k == 1) begin
         e.reg_ab_en = 1'b1;
         e.retired   = (o == 4'h0) || (o == 4'hF);
      end else if (k == 2) begin
         if (o >= 4'h1 && o <= 4'h5) begin
            e.alu_op   = 3'(o - 4'd1);
            e.acc_en   = 1'b1;
            e.flags_en = 1'b1;
         end else if (o == 4'h6) begin
            e.alu_b_sel = 1'b1;
            e.acc_en    = 1'b1;
            e.flags_en  = 1'b1;
         end else if (o == 4'h7 || o == 4'h8) begin
            e.alu_b_sel = 1'b1;
            e.mar_en    = 1'b1;
         end else begin
            e.pc_sel  = 1'b1;
            e.pc_en   = taken(o, z, n);
            e.retired = 1'b1;
         end
      end else if (k == 3) begin
         if (o == 4'h7) begin
            e.mdr_en = 1'b1;
         end else if (o == 4'h8) begin
            e.mem_we  = 1'b1;
            e.retired = 1'b1;
         end else begin
            e.rf_we   = 1'b1;
            e.retired = 1'b1;
         end
      end else begin
         e.rf_we   = 1'b1;
         e.wb_sel  = 1'b1;
         e.retired = 1'b1;
      end
      return e;
   endfunction

   // Model state: m_k = -1 is the post-reset idle cycle; m_stop 1 = HLT, 2 = illegal
   int    m_k    = -1;
   int    m_stop = 0;
   ctrl_t m_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_exp  = '0;
         m_k    = -1;
         m_stop = 0;
      end else if (m_stop == 1) begin
         m_exp        = '0;
         m_exp.halted = 1'b1;
      end else if (m_stop == 2) begin
         m_exp         = '0;
         m_exp.illegal = 1'b1;
      end else if (m_k < 0) begin
         m_exp = '0;
         m_k   = 0;
      end else begin
         m_exp = model_vec(bus.opcode, bus.flag_z, bus.flag_n, m_k);
         m_k++;
         if (m_k == instr_len(bus.opcode)) begin
            m_k = 0;
            if (bus.opcode == 4'hF)
               m_stop = 1;
            else if (bus.opcode == 4'hD || bus.opcode == 4'hE)
               m_stop = 2;
         end
      end
      check("cycle", 32'(dut_vec()), 32'(m_exp));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic peek();
      @(negedge clk);
   endtask

   // Called 2 time units after the edge that enters FETCH
   task automatic do_instr(input logic [3:0] o, input logic z, input logic n);
      bus.opcode = o;
      bus.flag_z = z;
      bus.flag_n = n;
      repeat (instr_len(o)) step();
   endtask

   logic [3:0] t_op [13] = '{4'h6, 4'h2, 4'h3, 4'h4, 4'h5, 4'hA, 4'hA, 4'hB, 4'hC, 4'h0, 4'h7, 4'h8, 4'h1};
   logic       t_z  [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic       t_n  [13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      bus.opcode = 4'h1;
      bus.flag_z = 1'b0;
      bus.flag_n = 1'b0;
      #1 rst_n = 1'b0;

      repeat (3) peek();
      check("reset_outs", 32'(dut_vec()), 32'(L_ZERO));

      step();
      rst_n = 1'b1;
      peek();
      check("init_cycle", 32'(dut_vec()), 32'(L_ZERO));
      step();
      peek();
      check("first_fetch", 32'(dut_vec()), 32'(L_FETCH));
      step();
      peek();
      check("add_decode", 32'(dut_vec()), 32'(L_DECODE));
      step();
      peek();
      check("add_exec", 32'(dut_vec()), 32'(L_EXEC_ADD));
      step();
      peek();
      check("add_wb", 32'(dut_vec()), 32'(L_WB));
      step();

      // LD
      bus.opcode = 4'h7;
      step();
      step();
      peek();
      check("ld_mar", 32'(dut_vec()), 32'(L_MAR));
      step();
      peek();
      check("ld_mdr", 32'(dut_vec()), 32'(L_MDR));
      step();
      peek();
      check("ld_wb", 32'(dut_vec()), 32'(L_WB_LD));
      step();

      // ST
      bus.opcode = 4'h8;
      step();
      step();
      step();
      peek();
      check("st_mem", 32'(dut_vec()), 32'(L_ST_MEM));
      step();

      // Branches
      bus.opcode = 4'h9;
      bus.flag_z = 1'b1;
      step();
      step();
      peek();
      check("beq_taken", 32'(dut_vec()), 32'(L_BR_TAKEN));
      step();

      bus.flag_z = 1'b0;
      step();
      step();
      peek();
      check("beq_not_taken", 32'(dut_vec()), 32'(L_BR_NOT));
      step();

      bus.opcode = 4'hB;
      bus.flag_n = 1'b1;
      step();
      step();
      peek();
      check("blt_taken", 32'(dut_vec()), 32'(L_BR_TAKEN));
      step();

      for (int i = 0; i < 13; i++)
         do_instr(t_op[i], t_z[i], t_n[i]);

      // Reset dropped in WB of an ADD
      bus.opcode = 4'h1;
      bus.flag_z = 1'b0;
      bus.flag_n = 1'b0;
      step();
      step();
      step();
      #1;
      check("wb_rf_we", 32'(bus.rf_we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async", 32'(dut_vec()), 32'(L_ZERO));
      step();
      rst_n = 1'b1;
      peek();
      check("post_rst_init", 32'(dut_vec()), 32'(L_ZERO));
      step();
      bus.opcode = 4'h0;
      peek();
      check("post_rst_fetch", 32'(dut_vec()), 32'(L_FETCH));
      step();
      peek();
      check("nop_decode", 32'(dut_vec()), 32'(L_DEC_RET));
      step();

      // HLT
      bus.opcode = 4'hF;
      step();
      peek();
      check("hlt_decode", 32'(dut_vec()), 32'(L_DEC_RET));
      step();
      for (int i = 0; i < 100; i++) begin
         bus.opcode = 4'($urandom_range(0, 15));
         bus.flag_z = 1'($urandom_range(0, 1));
         peek();
         if (i == 0 || i == 99)
            check("halted_hold", 32'(dut_vec()), 32'(L_HALTED));
         step();
      end

      // Illegal opcode
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      bus.opcode = 4'hE;
      step();
      peek();
      check("ill_decode", 32'(dut_vec()), 32'(L_DECODE));
      step();
      peek();
      check("ill_halt", 32'(dut_vec()), 32'(L_ILLEGAL));
      repeat (5) step();
      peek();
      check("ill_hold", 32'(dut_vec()), 32'(L_ILLEGAL));
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
